// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stage-control unit for the 5-stage MIPS core: load-use stall,
// branch flush, memory-busy freeze, optional single-step debug, forwarding selects and perf counters.
module hazard_ctrl #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned BR_FLUSH = 1,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned DEBUG_EN = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              debug_en,
  input  logic              debug_step,
  input  logic [ADDR_W-1:0] addr_rs,
  input  logic [ADDR_W-1:0] addr_rt,
  input  logic              rs_used,
  input  logic              rt_used,
  input  logic              is_store,
  input  logic [ADDR_W-1:0] regw_addr_exe,
  input  logic              wb_wen_exe,
  input  logic              mem_ren_exe,
  input  logic [ADDR_W-1:0] regw_addr_mem,
  input  logic              wb_wen_mem,
  input  logic              mem_ren_mem,
  input  logic              jump_en,
  input  logic              mem_busy,
  output logic              if_rst,
  output logic              id_rst,
  output logic              exe_rst,
  output logic              mem_rst,
  output logic              wb_rst,
  output logic              if_en,
  output logic              id_en,
  output logic              exe_en,
  output logic              mem_en,
  output logic              wb_en,
  output logic [1:0]        exe_fwd_a_ctrl,
  output logic [1:0]        exe_fwd_b_ctrl,
  output logic              mem_fwd_m,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_cycles
);

  localparam int unsigned LC_W = 4;

  logic [LC_W-1:0]  ld_cnt_q, ld_cnt_d;
  logic [LC_W-1:0]  br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_cycles_q, flush_cycles_d;
  logic             debug_step_prev_q, debug_step_prev_d;

  logic hit_exe_rs, hit_exe_rt, hit_mem_rs, hit_mem_rt;
  logic lu, dbg_hold, hold, stall_eff, flush_eff;

  // Select for one operand; an EXE ALU result is newer than anything in MEM.
  function automatic logic [1:0] fwd_sel(input logic used, input logic hit_e, input logic ld_e,
                                         input logic hit_m, input logic ld_m);
    logic [1:0] sel;
    sel = 2'd0;
    if (used && hit_m) sel = ld_m ? 2'd3 : 2'd2;
    if (used && hit_e && !ld_e) sel = 2'd1;
    return sel;
  endfunction

  always_comb begin
    hit_exe_rs = wb_wen_exe && (regw_addr_exe == addr_rs) && (regw_addr_exe != '0);
    hit_exe_rt = wb_wen_exe && (regw_addr_exe == addr_rt) && (regw_addr_exe != '0);
    hit_mem_rs = wb_wen_mem && (regw_addr_mem == addr_rs) && (regw_addr_mem != '0);
    hit_mem_rt = wb_wen_mem && (regw_addr_mem == addr_rt) && (regw_addr_mem != '0);

    lu        = mem_ren_exe && ((rs_used && hit_exe_rs) || (rt_used && !is_store && hit_exe_rt));
    dbg_hold  = (DEBUG_EN != 0) && debug_en && !(debug_step && !debug_step_prev_q);
    hold      = dbg_hold || mem_busy;
    stall_eff = !hold && (lu || (ld_cnt_q != '0));
    flush_eff = !hold && !stall_eff && (jump_en || (br_cnt_q != '0));
  end

  // Next-state for the stall/flush counters, perf counters and step edge detector.
  always_comb begin
    ld_cnt_d          = ld_cnt_q;
    br_cnt_d          = br_cnt_q;
    stall_cycles_d    = stall_cycles_q;
    flush_cycles_d    = flush_cycles_q;
    debug_step_prev_d = debug_step;

    if (!hold) begin
      if (ld_cnt_q != '0)   ld_cnt_d = ld_cnt_q - LC_W'(1);
      else if (lu)          ld_cnt_d = LC_W'(LOAD_LAT - 1);

      // A jump that loses to a stall keeps its full length for after the stall.
      if (jump_en)          br_cnt_d = stall_eff ? LC_W'(BR_FLUSH) : LC_W'(BR_FLUSH - 1);
      else if (br_cnt_q != '0 && !stall_eff) br_cnt_d = br_cnt_q - LC_W'(1);
    end

    if (stall_eff && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + CNT_W'(1);
    if (flush_eff && (flush_cycles_q != '1)) flush_cycles_d = flush_cycles_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_cnt_q          <= '0;
      br_cnt_q          <= '0;
      stall_cycles_q    <= '0;
      flush_cycles_q    <= '0;
      debug_step_prev_q <= 1'b0;
    end else begin
      ld_cnt_q          <= ld_cnt_d;
      br_cnt_q          <= br_cnt_d;
      stall_cycles_q    <= stall_cycles_d;
      flush_cycles_q    <= flush_cycles_d;
      debug_step_prev_q <= debug_step_prev_d;
    end
  end

  // Stage control and forwarding outputs.
  always_comb begin
    if_rst         = 1'b0;
    id_rst         = flush_eff;
    exe_rst        = stall_eff;
    mem_rst        = 1'b0;
    wb_rst         = mem_busy && !dbg_hold;
    if_en          = !hold && !stall_eff;
    id_en          = !hold && !stall_eff;
    exe_en         = !hold;
    mem_en         = !hold;
    wb_en          = !dbg_hold;
    exe_fwd_a_ctrl = fwd_sel(rs_used, hit_exe_rs, mem_ren_exe, hit_mem_rs, mem_ren_mem);
    exe_fwd_b_ctrl = fwd_sel(rt_used, hit_exe_rt, mem_ren_exe, hit_mem_rt, mem_ren_mem);
    mem_fwd_m      = rt_used && is_store && mem_ren_exe && hit_exe_rt;

    if (rst) begin
      {if_rst, id_rst, exe_rst, mem_rst, wb_rst} = 5'b11111;
      {if_en, id_en, exe_en, mem_en, wb_en}      = 5'b11111;
      exe_fwd_a_ctrl = 2'd0;
      exe_fwd_b_ctrl = 2'd0;
      mem_fwd_m      = 1'b0;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_cycles = flush_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: u3 (LOAD_LAT=3, BR_FLUSH=2, debug on) and
// u1 (LOAD_LAT=1, BR_FLUSH=1, 2-bit counters, debug off) share all inputs.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst, debug_en, debug_step;
  logic [4:0] addr_rs, addr_rt, regw_addr_exe, regw_addr_mem;
  logic rs_used, rt_used, is_store, wb_wen_exe, mem_ren_exe, wb_wen_mem, mem_ren_mem;
  logic jump_en, mem_busy;

  logic if_rst_3, id_rst_3, exe_rst_3, mem_rst_3, wb_rst_3;
  logic if_en_3, id_en_3, exe_en_3, mem_en_3, wb_en_3;
  logic [1:0] fwd_a_3, fwd_b_3;
  logic mem_fwd_m_3;
  logic [31:0] stall_cycles_3, flush_cycles_3;

  logic if_rst_1, id_rst_1, exe_rst_1, mem_rst_1, wb_rst_1;
  logic if_en_1, id_en_1, exe_en_1, mem_en_1, wb_en_1;
  logic [1:0] fwd_a_1, fwd_b_1;
  logic mem_fwd_m_1;
  logic [1:0] stall_cycles_1, flush_cycles_1;

  wire [4:0] rst_3 = {if_rst_3, id_rst_3, exe_rst_3, mem_rst_3, wb_rst_3};
  wire [4:0] en_3  = {if_en_3, id_en_3, exe_en_3, mem_en_3, wb_en_3};
  wire [4:0] rst_1 = {if_rst_1, id_rst_1, exe_rst_1, mem_rst_1, wb_rst_1};
  wire [4:0] en_1  = {if_en_1, id_en_1, exe_en_1, mem_en_1, wb_en_1};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.ADDR_W(5), .LOAD_LAT(3), .BR_FLUSH(2), .CNT_W(32), .DEBUG_EN(1)) u3 (
    .clk(clk), .rst(rst), .debug_en(debug_en), .debug_step(debug_step),
    .addr_rs(addr_rs), .addr_rt(addr_rt), .rs_used(rs_used), .rt_used(rt_used),
    .is_store(is_store), .regw_addr_exe(regw_addr_exe), .wb_wen_exe(wb_wen_exe),
    .mem_ren_exe(mem_ren_exe), .regw_addr_mem(regw_addr_mem), .wb_wen_mem(wb_wen_mem),
    .mem_ren_mem(mem_ren_mem), .jump_en(jump_en), .mem_busy(mem_busy),
    .if_rst(if_rst_3), .id_rst(id_rst_3), .exe_rst(exe_rst_3), .mem_rst(mem_rst_3),
    .wb_rst(wb_rst_3), .if_en(if_en_3), .id_en(id_en_3), .exe_en(exe_en_3),
    .mem_en(mem_en_3), .wb_en(wb_en_3), .exe_fwd_a_ctrl(fwd_a_3), .exe_fwd_b_ctrl(fwd_b_3),
    .mem_fwd_m(mem_fwd_m_3), .stall_cycles(stall_cycles_3), .flush_cycles(flush_cycles_3)
  );

  hazard_ctrl #(.ADDR_W(5), .LOAD_LAT(1), .BR_FLUSH(1), .CNT_W(2), .DEBUG_EN(0)) u1 (
    .clk(clk), .rst(rst), .debug_en(debug_en), .debug_step(debug_step),
    .addr_rs(addr_rs), .addr_rt(addr_rt), .rs_used(rs_used), .rt_used(rt_used),
    .is_store(is_store), .regw_addr_exe(regw_addr_exe), .wb_wen_exe(wb_wen_exe),
    .mem_ren_exe(mem_ren_exe), .regw_addr_mem(regw_addr_mem), .wb_wen_mem(wb_wen_mem),
    .mem_ren_mem(mem_ren_mem), .jump_en(jump_en), .mem_busy(mem_busy),
    .if_rst(if_rst_1), .id_rst(id_rst_1), .exe_rst(exe_rst_1), .mem_rst(mem_rst_1),
    .wb_rst(wb_rst_1), .if_en(if_en_1), .id_en(id_en_1), .exe_en(exe_en_1),
    .mem_en(mem_en_1), .wb_en(wb_en_1), .exe_fwd_a_ctrl(fwd_a_1), .exe_fwd_b_ctrl(fwd_b_1),
    .mem_fwd_m(mem_fwd_m_1), .stall_cycles(stall_cycles_1), .flush_cycles(flush_cycles_1)
  );

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    debug_en = 0; debug_step = 0;
    addr_rs = 0; addr_rt = 0; rs_used = 0; rt_used = 0; is_store = 0;
    regw_addr_exe = 0; wb_wen_exe = 0; mem_ren_exe = 0;
    regw_addr_mem = 0; wb_wen_mem = 0; mem_ren_mem = 0;
    jump_en = 0; mem_busy = 0;
  endtask

  // lw $3 in EXE, ID instruction reads $3 through rs
  task automatic drive_lu();
    idle();
    regw_addr_exe = 5'd3; wb_wen_exe = 1; mem_ren_exe = 1;
    addr_rs = 5'd3; rs_used = 1; addr_rt = 5'd7; rt_used = 1;
  endtask

  // same ID instruction, the load has moved on to MEM
  task automatic drive_load_in_mem();
    idle();
    regw_addr_mem = 5'd3; wb_wen_mem = 1; mem_ren_mem = 1;
    addr_rs = 5'd3; rs_used = 1; addr_rt = 5'd7; rt_used = 1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    cyc(); cyc();
    rst = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    drive_lu(); jump_en = 1; mem_busy = 1;
    #1;
    checks++; if (rst_3 !== 5'b11111) begin errors++; $display("FAIL reset_rsts: got %b exp 11111", rst_3); end
    checks++; if (en_3 !== 5'b11111) begin errors++; $display("FAIL reset_ens: got %b exp 11111", en_3); end
    checks++; if ({fwd_a_3, fwd_b_3, mem_fwd_m_3} !== 5'b0) begin errors++; $display("FAIL reset_fwd: got %b exp 00000", {fwd_a_3, fwd_b_3, mem_fwd_m_3}); end
    cyc();
    checks++; if ({stall_cycles_3, flush_cycles_3} !== 64'd0) begin errors++; $display("FAIL reset_counters: got %0d/%0d exp 0/0", stall_cycles_3, flush_cycles_3); end
    idle(); rst = 0;
    #1;
    checks++; if (rst_3 !== 5'b00000 || en_3 !== 5'b11111) begin errors++; $display("FAIL post_reset_idle: got rst %b en %b exp 00000 11111", rst_3, en_3); end
    cyc();
  endtask

  task automatic test_load_lat1();
    do_reset();
    drive_lu(); #1;
    checks++; if (en_1 !== 5'b00111 || rst_1 !== 5'b00100) begin errors++; $display("FAIL lat1_stall: got en %b rst %b exp 00111 00100", en_1, rst_1); end
    cyc();
    drive_load_in_mem(); #1;
    checks++; if (en_1 !== 5'b11111 || rst_1 !== 5'b00000) begin errors++; $display("FAIL lat1_release: got en %b rst %b exp 11111 00000", en_1, rst_1); end
    checks++; if (fwd_a_1 !== 2'd3) begin errors++; $display("FAIL lat1_fwd_a: got %0d exp 3", fwd_a_1); end
    checks++; if (stall_cycles_1 !== 2'd1) begin errors++; $display("FAIL lat1_stall_cycles: got %0d exp 1", stall_cycles_1); end
    cyc();
  endtask

  task automatic test_load_lat3();
    do_reset();
    drive_lu(); #1;
    checks++; if (en_3 !== 5'b00111 || rst_3 !== 5'b00100) begin errors++; $display("FAIL lat3_c0: got en %b rst %b exp 00111 00100", en_3, rst_3); end
    for (int c = 1; c <= 2; c++) begin
      cyc();
      drive_load_in_mem(); #1;
      checks++; if (en_3 !== 5'b00111 || rst_3 !== 5'b00100) begin errors++; $display("FAIL lat3_c%0d: got en %b rst %b exp 00111 00100", c, en_3, rst_3); end
      checks++; if (stall_cycles_3 !== 32'(c)) begin errors++; $display("FAIL lat3_cnt_c%0d: got %0d exp %0d", c, stall_cycles_3, c); end
    end
    cyc();
    drive_load_in_mem(); #1;
    checks++; if (en_3 !== 5'b11111 || rst_3 !== 5'b00000) begin errors++; $display("FAIL lat3_release: got en %b rst %b exp 11111 00000", en_3, rst_3); end
    checks++; if (fwd_a_3 !== 2'd3 || stall_cycles_3 !== 32'd3) begin errors++; $display("FAIL lat3_fwd_cnt: got fwd %0d cnt %0d exp 3 3", fwd_a_3, stall_cycles_3); end
    cyc();
  endtask

  task automatic test_forwarding();
    do_reset();
    addr_rs = 5'd5; addr_rt = 5'd5; rs_used = 1; rt_used = 1;
    regw_addr_exe = 5'd5; wb_wen_exe = 1; regw_addr_mem = 5'd5; wb_wen_mem = 1; #1;
    checks++; if ({fwd_a_3, fwd_b_3} !== 4'b0101) begin errors++; $display("FAIL fwd_exe_over_mem: got %0d/%0d exp 1/1", fwd_a_3, fwd_b_3); end
    wb_wen_exe = 0; #1;
    checks++; if ({fwd_a_3, fwd_b_3} !== 4'b1010) begin errors++; $display("FAIL fwd_mem_alu: got %0d/%0d exp 2/2", fwd_a_3, fwd_b_3); end
    mem_ren_mem = 1; #1;
    checks++; if ({fwd_a_3, fwd_b_3} !== 4'b1111) begin errors++; $display("FAIL fwd_mem_dm: got %0d/%0d exp 3/3", fwd_a_3, fwd_b_3); end
    rs_used = 0; #1;
    checks++; if ({fwd_a_3, fwd_b_3} !== 4'b0011) begin errors++; $display("FAIL fwd_unused_rs: got %0d/%0d exp 0/3", fwd_a_3, fwd_b_3); end
    rs_used = 1; mem_ren_mem = 0; addr_rs = 0; addr_rt = 0;
    regw_addr_exe = 0; wb_wen_exe = 1; regw_addr_mem = 0; wb_wen_mem = 1; #1;
    checks++; if ({fwd_a_3, fwd_b_3} !== 4'b0000) begin errors++; $display("FAIL fwd_reg0: got %0d/%0d exp 0/0", fwd_a_3, fwd_b_3); end
    cyc();
  endtask

  task automatic test_store_after_load();
    do_reset();
    regw_addr_exe = 5'd4; wb_wen_exe = 1; mem_ren_exe = 1;
    addr_rs = 5'd2; rs_used = 1; addr_rt = 5'd4; rt_used = 1; is_store = 1; #1;
    checks++; if (mem_fwd_m_3 !== 1'b1) begin errors++; $display("FAIL sw_fwd_m: got %b exp 1", mem_fwd_m_3); end
    checks++; if (en_3 !== 5'b11111 || rst_3 !== 5'b00000) begin errors++; $display("FAIL sw_no_stall: got en %b rst %b exp 11111 00000", en_3, rst_3); end
    cyc(); idle(); #1;
    checks++; if (stall_cycles_3 !== 32'd0 || mem_fwd_m_3 !== 1'b0) begin errors++; $display("FAIL sw_after: got cnt %0d fwd_m %b exp 0 0", stall_cycles_3, mem_fwd_m_3); end
  endtask

  task automatic test_branch_flush();
    do_reset();
    jump_en = 1; #1;
    checks++; if (id_rst_3 !== 1'b1 || id_rst_1 !== 1'b1) begin errors++; $display("FAIL br_c0: got %b/%b exp 1/1", id_rst_3, id_rst_1); end
    cyc(); jump_en = 0; #1;
    checks++; if (id_rst_3 !== 1'b1 || id_rst_1 !== 1'b0) begin errors++; $display("FAIL br_c1: got %b/%b exp 1/0", id_rst_3, id_rst_1); end
    cyc(); #1;
    checks++; if (id_rst_3 !== 1'b0 || flush_cycles_3 !== 32'd2) begin errors++; $display("FAIL br_end: got id_rst %b cnt %0d exp 0 2", id_rst_3, flush_cycles_3); end
    checks++; if (flush_cycles_1 !== 2'd1) begin errors++; $display("FAIL br_lat1_cnt: got %0d exp 1", flush_cycles_1); end
    jump_en = 1; cyc();
    #1;
    checks++; if (id_rst_3 !== 1'b1) begin errors++; $display("FAIL br_retrig_c1: got %b exp 1", id_rst_3); end
    cyc(); jump_en = 0; #1;
    checks++; if (id_rst_3 !== 1'b1) begin errors++; $display("FAIL br_retrig_c2: got %b exp 1", id_rst_3); end
    cyc(); #1;
    checks++; if (id_rst_3 !== 1'b0 || flush_cycles_3 !== 32'd5) begin errors++; $display("FAIL br_retrig_end: got id_rst %b cnt %0d exp 0 5", id_rst_3, flush_cycles_3); end
  endtask

  task automatic test_mem_busy_freeze();
    do_reset();
    drive_lu(); cyc();
    idle(); cyc();
    mem_busy = 1; jump_en = 1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (en_3 !== 5'b00001 || rst_3 !== 5'b00001) begin errors++; $display("FAIL busy_c%0d: got en %b rst %b exp 00001 00001", c, en_3, rst_3); end
      checks++; if (stall_cycles_3 !== 32'd2 || flush_cycles_3 !== 32'd0) begin errors++; $display("FAIL busy_cnt_c%0d: got %0d/%0d exp 2/0", c, stall_cycles_3, flush_cycles_3); end
      cyc();
    end
    idle(); #1;
    checks++; if (en_3 !== 5'b00111 || rst_3 !== 5'b00100) begin errors++; $display("FAIL busy_resume: got en %b rst %b exp 00111 00100", en_3, rst_3); end
    cyc(); #1;
    checks++; if (en_3 !== 5'b11111 || stall_cycles_3 !== 32'd3) begin errors++; $display("FAIL busy_done: got en %b cnt %0d exp 11111 3", en_3, stall_cycles_3); end
    drive_lu(); cyc();
    idle(); rst = 1; #1;
    checks++; if (rst_3 !== 5'b11111 || en_3 !== 5'b11111) begin errors++; $display("FAIL rst_mid_stall: got rst %b en %b exp 11111 11111", rst_3, en_3); end
    cyc(); rst = 0; #1;
    checks++; if (en_3 !== 5'b11111 || rst_3 !== 5'b00000 || stall_cycles_3 !== 32'd0) begin errors++; $display("FAIL rst_mid_after: got en %b rst %b cnt %0d exp 11111 00000 0", en_3, rst_3, stall_cycles_3); end
    cyc();
  endtask

  task automatic test_stall_and_jump();
    do_reset();
    drive_lu(); jump_en = 1; #1;
    checks++; if (rst_3 !== 5'b00100) begin errors++; $display("FAIL sj_stall_wins: got rst %b exp 00100", rst_3); end
    cyc(); idle(); cyc(); #1;
    checks++; if (id_rst_3 !== 1'b0 || exe_rst_3 !== 1'b1) begin errors++; $display("FAIL sj_still_stalled: got id %b exe %b exp 0 1", id_rst_3, exe_rst_3); end
    cyc(); #1;
    checks++; if (rst_3 !== 5'b01000) begin errors++; $display("FAIL sj_flush_c1: got rst %b exp 01000", rst_3); end
    cyc(); #1;
    checks++; if (rst_3 !== 5'b01000) begin errors++; $display("FAIL sj_flush_c2: got rst %b exp 01000", rst_3); end
    cyc(); #1;
    checks++; if (id_rst_3 !== 1'b0 || flush_cycles_3 !== 32'd2 || stall_cycles_3 !== 32'd3) begin errors++; $display("FAIL sj_end: got id %b flush %0d stall %0d exp 0 2 3", id_rst_3, flush_cycles_3, stall_cycles_3); end
  endtask

  task automatic test_debug_step();
    do_reset();
    debug_en = 1; #1;
    checks++; if (en_3 !== 5'b00000 || en_1 !== 5'b11111) begin errors++; $display("FAIL dbg_hold: got en3 %b en1 %b exp 00000 11111", en_3, en_1); end
    cyc(); debug_step = 1; #1;
    checks++; if (en_3 !== 5'b11111) begin errors++; $display("FAIL dbg_step_edge: got en %b exp 11111", en_3); end
    cyc(); #1;
    checks++; if (en_3 !== 5'b00000) begin errors++; $display("FAIL dbg_step_level: got en %b exp 00000", en_3); end
    idle(); cyc();
  endtask

  task automatic test_saturate();
    do_reset();
    drive_lu();
    for (int c = 0; c < 5; c++) cyc();
    #1;
    checks++; if (stall_cycles_1 !== 2'd3) begin errors++; $display("FAIL sat_stall_cycles: got %0d exp 3", stall_cycles_1); end
    idle(); cyc();
  endtask

  initial begin
    idle();
    rst = 1;
    cyc();
    test_reset();
    test_load_lat1();
    test_load_lat3();
    test_forwarding();
    test_store_after_load();
    test_branch_flush();
    test_mem_busy_freeze();
    test_stall_and_jump();
    test_debug_step();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
